vcve2_vec_elem_seq: RTL and testbench
=====================================

VCVE2_VEC_ELEM_SEQ -- requirements
Module: vcve2_vec_elem_seq

Interface
REQ-001 Parameter VLEN, default 128, SHALL set the vector register length in bits (multiple of 32, 64..1024); NW = VLEN/32 words.
REQ-002 Port clk_i, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_i, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port start_i, input, 1, SHALL request a vector operation; accepted when start_i & ready_o.
REQ-005 Port vl_i, input, $clog2(VLEN/8)+1, SHALL give the element count; sampled on accept.
REQ-006 Port vsew_i, input, 3, SHALL give the SEW encoding (VSEW_8/16/32 from vcve2_pkg); sampled on accept.
REQ-007 Port flush_i, input, 1, SHALL abort any operation.
REQ-008 Port ex_valid_i, input, 1, SHALL indicate that the EX block finished the current word.
REQ-009 Port ready_o, output, 1, SHALL indicate that the block is idle and accepting.
REQ-010 Port ex_req_o, output, 1, SHALL indicate that a word operation is presented to EX.
REQ-011 Port ex_first_cycle_o, output, 1, SHALL mark the first cycle of each word (drives the ALU instr_first_cycle).
REQ-012 Port word_idx_o, output, $clog2(NW), SHALL give the current word index.
REQ-013 Port byte_en_o, output, 4, SHALL give the active-byte mask of the current word.
REQ-014 Port last_o, output, 1, SHALL mark the final word.
REQ-015 Port done_o, output, 1, SHALL be a one-cycle completion pulse.
REQ-016 Port err_o, output, 1, SHALL be a one-cycle illegal-configuration pulse.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; ready_o=1 only in IDLE.
REQ-018 On accept: if vsew_i is reserved (not 8/16/32) or vl_i > VLEN/SEW, the block SHALL pulse err_o next cycle and stay IDLE.
REQ-019 On accept with vl_i=0, the FSM SHALL go to DONE (no ex_req_o).
REQ-020 On an otherwise legal accept, the FSM SHALL go to BUSY; bytes B = vl*SEW/8, words W = ceil(B/4), word_idx = 0.
REQ-021 In BUSY, ex_req_o=1; ex_first_cycle_o=1 on the first cycle after entry or advance; held values remain stable until ex_valid_i.
REQ-022 On ex_valid_i in BUSY with word_idx < W-1, word_idx SHALL increment next cycle.
REQ-023 On ex_valid_i with word_idx = W-1, the FSM SHALL go to DONE.
REQ-024 byte_en_o SHALL be 4'b1111 except on the last word when B mod 4 != 0, where it is (1<<(B mod 4))-1.
REQ-025 last_o SHALL be (word_idx = W-1) in BUSY, else 0.
REQ-026 DONE SHALL last exactly one cycle, asserting done_o; the FSM then goes to IDLE.
REQ-027 Latency: accept at cycle T with a single-cycle EX gives done_o at T+1+W.
REQ-028 flush_i SHALL force IDLE next cycle from any state with no done_o/err_o; flush_i and start_i together SHALL drop the start.
REQ-029 ex_valid_i outside BUSY SHALL be ignored.

Reset
REQ-030 With rst_i high at an edge: state IDLE, word_idx 0, ready_o=1, and all other outputs 0; rst_i SHALL override flush_i and start_i.

Configuration
REQ-031 With VCVE2_VSEQ_PERF_CNT_EN defined, output perf_busy_cnt_o[31:0] SHALL count BUSY cycles, saturating at 2^32-1, cleared only by rst_i.
REQ-032 Without VCVE2_VSEQ_PERF_CNT_EN, neither the port nor the counter exists.

Structure
REQ-033 vcve2_pkg SHALL hold vseq_state_e (IDLE/BUSY/DONE) alongside the existing VSEW encodings.
REQ-034 Sub-module vcve2_vseq_geom (combinational: vl, vsew -> W, tail mask, legality) SHALL be instantiated once.

Verification
REQ-035 vl=5, SEW16, ex_valid_i held 1 -> W=3, byte_en 1111/1111/0011, done_o at T+4.
REQ-036 vl=16, SEW8, VLEN=128 -> 4 words, all byte_en 1111, last_o on word 3.
REQ-037 vl=5, SEW32 (VLMAX 4) -> err_o pulse at T+1, no ex_req_o, ready_o stays 1.
REQ-038 vl=0 -> done_o at T+1, no ex_req_o.
REQ-039 vl=8, SEW32, ex_valid_i low for 3 cycles on word 1 -> word_idx_o holds 1 and ex_first_cycle_o is high only on the first of those cycles.
REQ-040 flush_i on word 2 of 4 -> IDLE next cycle, no done_o; rst_i mid-BUSY -> reset values.

Source files
------------

// File: rtl/vcve2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vcve2_pkg
// Purpose  : Shared SEW encodings, vector-sequencer state type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vcve2_pkg;

    localparam logic [2:0] VSEW_8  = 3'b000;
    localparam logic [2:0] VSEW_16 = 3'b001;
    localparam logic [2:0] VSEW_32 = 3'b010;

    typedef enum logic [1:0] {
        VSEQ_IDLE = 2'd0,
        VSEQ_BUSY = 2'd1,
        VSEQ_DONE = 2'd2
    } vseq_state_e;

    // Byte mask for a partially filled word; rem == 0 means the word is full.
    function automatic logic [3:0] tail_mask(input logic [1:0] rem);
        return (rem == 2'd0) ? 4'hF : 4'((5'd1 << rem) - 5'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vcve2_vseq_geom.sv
`default_nettype none
// ============================================================================
// Module   : vcve2_vseq_geom
// Purpose  : Combinational operation geometry: legality, last word index and
//            tail byte mask derived from vl and vsew.
// Revision : 1.0 - initial release
// ============================================================================
module vcve2_vseq_geom
    import vcve2_pkg::*;
#(
    parameter  int unsigned VLEN = 128,
    localparam int unsigned NW   = VLEN / 32,
    localparam int unsigned VLW  = $clog2(VLEN / 8) + 1,
    localparam int unsigned IW   = $clog2(NW)
) (
    input  logic [VLW-1:0] i_vl,
    input  logic [2:0]     i_vsew,
    output logic           o_legal,
    output logic           o_zero,
    output logic [IW-1:0]  o_last_idx,
    output logic [3:0]     o_tail_be
);

    // vl * 4 always fits, so no overflow on the byte count
    localparam int unsigned BW = VLW + 2;

    logic [1:0]    w_shift;
    logic          w_sew_ok;
    logic [BW-1:0] w_vlmax;
    logic [BW-1:0] w_bytes;

    always_comb begin
        w_shift  = 2'd0;
        w_sew_ok = 1'b1;
        case (i_vsew)
            VSEW_8:  w_shift = 2'd0;
            VSEW_16: w_shift = 2'd1;
            VSEW_32: w_shift = 2'd2;
            default: w_sew_ok = 1'b0;
        endcase
        w_vlmax = BW'(VLEN / 8) >> w_shift;
        w_bytes = BW'(i_vl) << w_shift;
    end

    assign o_legal    = w_sew_ok && (BW'(i_vl) <= w_vlmax);
    assign o_zero     = (i_vl == '0);
    assign o_last_idx = IW'((w_bytes - BW'(1)) >> 2);
    assign o_tail_be  = tail_mask(w_bytes[1:0]);

endmodule
`default_nettype wire

// File: rtl/vcve2_vec_elem_seq.sv
`default_nettype none
// ============================================================================
// Module   : vcve2_vec_elem_seq
// Purpose  : Steps a vector operation word by word through the EX block.
//            Optional BUSY-cycle counter: define VCVE2_VSEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vcve2_vec_elem_seq
    import vcve2_pkg::*;
#(
    parameter  int unsigned VLEN = 128,
    localparam int unsigned NW   = VLEN / 32,
    localparam int unsigned VLW  = $clog2(VLEN / 8) + 1,
    localparam int unsigned IW   = $clog2(NW)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [VLW-1:0] vl_i,
    input  logic [2:0]     vsew_i,
    input  logic           flush_i,
    input  logic           ex_valid_i,
    output logic           ready_o,
    output logic           ex_req_o,
    output logic           ex_first_cycle_o,
    output logic [IW-1:0]  word_idx_o,
    output logic [3:0]     byte_en_o,
    output logic           last_o,
    output logic           done_o,
    output logic           err_o
`ifdef VCVE2_VSEQ_PERF_CNT_EN
    ,
    output logic [31:0]    perf_busy_cnt_o
`endif
);

    localparam logic [1:0] c_ST_IDLE = VSEQ_IDLE;
    localparam logic [1:0] c_ST_BUSY = VSEQ_BUSY;
    localparam logic [1:0] c_ST_DONE = VSEQ_DONE;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_last_idx;
    logic [3:0]    r_tail_be;
    logic          r_first;
    logic          r_err;

    logic          w_legal;
    logic          w_zero;
    logic [IW-1:0] w_last_idx;
    logic [3:0]    w_tail_be;
    logic          w_busy;
    logic          w_is_last;

    vcve2_vseq_geom #(
        .VLEN (VLEN)
    ) u_geom (
        .i_vl       (vl_i),
        .i_vsew     (vsew_i),
        .o_legal    (w_legal),
        .o_zero     (w_zero),
        .o_last_idx (w_last_idx),
        .o_tail_be  (w_tail_be)
    );

    assign w_busy    = (r_state == c_ST_BUSY);
    assign w_is_last = (r_idx == r_last_idx);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_tail_be  <= 4'hF;
            r_first    <= 1'b0;
            r_err      <= 1'b0;
        end else if (flush_i) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= 1'b0;
            r_first <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        if (!w_legal) begin
                            r_err <= 1'b1;
                        end else if (w_zero) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_state    <= c_ST_BUSY;
                            r_idx      <= '0;
                            r_last_idx <= w_last_idx;
                            r_tail_be  <= w_tail_be;
                            r_first    <= 1'b1;
                        end
                    end
                end
                c_ST_BUSY: begin
                    if (ex_valid_i) begin
                        if (w_is_last) begin
                            r_state <= c_ST_DONE;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_first <= 1'b1;
                        end
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign ready_o          = (r_state == c_ST_IDLE);
    assign ex_req_o         = w_busy;
    assign ex_first_cycle_o = r_first;
    assign word_idx_o       = r_idx;
    assign last_o           = w_busy && w_is_last;
    assign byte_en_o        = !w_busy ? 4'h0 : (w_is_last ? r_tail_be : 4'hF);
    assign done_o           = (r_state == c_ST_DONE);
    assign err_o            = r_err;

`ifdef VCVE2_VSEQ_PERF_CNT_EN
    logic [31:0] r_perf_busy_cnt;

    // Saturates rather than wraps; only reset clears it, flush does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_busy_cnt <= '0;
        end else if (w_busy && (r_perf_busy_cnt != '1)) begin
            r_perf_busy_cnt <= r_perf_busy_cnt + 32'd1;
        end
    end

    assign perf_busy_cnt_o = r_perf_busy_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vcve2_vec_elem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vcve2_vec_elem_seq
// Purpose  : Self-checking bench: table vectors, corner sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vcve2_vec_elem_seq;
    import vcve2_pkg::*;

    localparam int unsigned VLEN = 128;

    logic       clk = 1'b0;
    logic       rst, start, flush, ex_valid;
    logic [4:0] vl;
    logic [2:0] vsew;
    logic       ready, ex_req, first, last, done, err;
    logic [1:0] idx;
    logic [3:0] be;
`ifdef VCVE2_VSEQ_PERF_CNT_EN
    logic [31:0] perf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vcve2_vec_elem_seq #(.VLEN(VLEN)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .vl_i             (vl),
        .vsew_i           (vsew),
        .flush_i          (flush),
        .ex_valid_i       (ex_valid),
        .ready_o          (ready),
        .ex_req_o         (ex_req),
        .ex_first_cycle_o (first),
        .word_idx_o       (idx),
        .byte_en_o        (be),
        .last_o           (last),
        .done_o           (done),
        .err_o            (err)
`ifdef VCVE2_VSEQ_PERF_CNT_EN
        ,
        .perf_busy_cnt_o  (perf)
`endif
    );

    // Reference: element size in bits, zero for reserved encodings.
    function automatic int sew_bits(input logic [2:0] s);
        case (s)
            3'd0:    return 8;
            3'd1:    return 16;
            3'd2:    return 32;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_legal(input int v, input logic [2:0] s);
        int sb = sew_bits(s);
        return (sb != 0) && (v <= int'(VLEN) / sb);
    endfunction

    function automatic int m_bytes(input int v, input logic [2:0] s);
        return v * sew_bits(s) / 8;
    endfunction

    function automatic int m_words(input int v, input logic [2:0] s);
        return (m_bytes(v, s) + 3) / 4;
    endfunction

    function automatic logic [3:0] m_be(input int v, input logic [2:0] s, input int k);
        int b = m_bytes(v, s);
        if (k == m_words(v, s) - 1 && (b % 4) != 0) return 4'((1 << (b % 4)) - 1);
        return 4'hF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_req"},   ex_req, 0);
        chk({tag, "_first"}, first, 0);
        chk({tag, "_idx"},   idx, 0);
        chk({tag, "_be"},    be, 0);
        chk({tag, "_last"},  last, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
    endtask

    // mode 0: ex_valid always 1; 1: random; 2: three stall cycles on word 1
    task automatic run_op(input int vl_v, input logic [2:0] sew_v, input int mode,
                          output bit o_err, output int o_words, output logic [3:0] o_last_be);
        int k, cyc, stall_cnt, w;
        bit fexp, v;
        o_err = 0; o_words = 0; o_last_be = 4'h0;
        ex_valid = 1'b1;
        tick();
        chk("idle_ready", ready, 1);
        chk("idle_req", ex_req, 0);
        ex_valid = 1'b0;
        start = 1'b1; vl = 5'(vl_v); vsew = sew_v;
        tick();
        start = 1'b0; vl = 5'($urandom); vsew = 3'($urandom);
        o_err = err;
        if (!m_legal(vl_v, sew_v)) begin
            chk("illegal_err", err, 1);
            chk("illegal_ready", ready, 1);
            chk("illegal_req", ex_req, 0);
            tick();
            chk("illegal_err_pulse", err, 0);
            chk("illegal_req2", ex_req, 0);
            return;
        end
        chk("legal_err", err, 0);
        if (vl_v == 0) begin
            chk("vl0_done", done, 1);
            chk("vl0_req", ex_req, 0);
            tick();
            chk("vl0_done_pulse", done, 0);
            chk("vl0_ready", ready, 1);
            return;
        end
        w = m_words(vl_v, sew_v);
        k = 0; cyc = 0; stall_cnt = 0; fexp = 1;
        while (k < w && cyc < 100) begin
            chk("busy_req", ex_req, 1);
            chk("busy_ready", ready, 0);
            chk("busy_done", done, 0);
            chk("busy_idx", idx, k);
            chk("busy_be", be, m_be(vl_v, sew_v, k));
            chk("busy_last", last, (k == w - 1));
            chk("busy_first", first, fexp);
            if (first) o_words++;
            if (last) o_last_be = be;
            if (mode == 1)                          v = ($urandom_range(0, 2) != 0);
            else if (mode == 2 && k == 1 && stall_cnt < 3) begin v = 0; stall_cnt++; end
            else                                    v = 1;
            ex_valid = v;
            tick();
            cyc++;
            if (v) begin k++; fexp = 1; end
            else fexp = 0;
        end
        ex_valid = 1'b0;
        if (k < w) begin
            total++; bad++;
            $display("FAIL op_timeout: got %0d words expected %0d", k, w);
        end
        chk("end_done", done, 1);
        chk("end_req", ex_req, 0);
        tick();
        chk("end_done_pulse", done, 0);
        chk("end_ready", ready, 1);
    endtask

    typedef struct {
        int         vl;
        logic [2:0] sew;
        int         mode;
        bit         err;
        int         words;
        logic [3:0] last_be;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit         e;
        int         nw;
        logic [3:0] lb;

        tbl[0]  = '{5,  VSEW_16, 0, 0, 3, 4'b0011};
        tbl[1]  = '{16, VSEW_8,  0, 0, 4, 4'b1111};
        tbl[2]  = '{5,  VSEW_32, 0, 1, 0, 4'b0000};
        tbl[3]  = '{0,  VSEW_8,  0, 0, 0, 4'b0000};
        tbl[4]  = '{1,  VSEW_8,  0, 0, 1, 4'b0001};
        tbl[5]  = '{3,  VSEW_8,  0, 0, 1, 4'b0111};
        tbl[6]  = '{4,  VSEW_32, 2, 0, 4, 4'b1111};
        tbl[7]  = '{17, VSEW_8,  0, 1, 0, 4'b0000};
        tbl[8]  = '{8,  VSEW_16, 0, 0, 4, 4'b1111};
        tbl[9]  = '{9,  VSEW_16, 0, 1, 0, 4'b0000};
        tbl[10] = '{2,  3'b011,  0, 1, 0, 4'b0000};
        tbl[11] = '{7,  VSEW_16, 1, 0, 4, 4'b0011};
        tbl[12] = '{0,  3'b111,  0, 1, 0, 4'b0000};

        rst = 1'b1; start = 1'b0; flush = 1'b0; ex_valid = 1'b0; vl = '0; vsew = '0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].vl, tbl[i].sew, tbl[i].mode, e, nw, lb);
            chk("tbl_err", e, tbl[i].err);
            chk("tbl_words", nw, tbl[i].words);
            chk("tbl_last_be", lb, tbl[i].last_be);
        end

        // Flush on word 2 of 4, with start also raised.
        start = 1'b1; vl = 5'd16; vsew = VSEW_8;
        tick();
        start = 1'b0; ex_valid = 1'b1;
        tick();
        tick();
        chk("fl_idx2", idx, 2);
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0; ex_valid = 1'b0;
        chk("fl_ready", ready, 1);
        chk("fl_req", ex_req, 0);
        chk("fl_done", done, 0);
        tick();
        chk("fl_done2", done, 0);
        chk("fl_req2", ex_req, 0);

        // Flush with start in IDLE drops the start; flush suppresses err.
        flush = 1'b1; start = 1'b1; vl = 5'd4; vsew = VSEW_8;
        tick();
        chk("fls_req", ex_req, 0);
        chk("fls_ready", ready, 1);
        vl = 5'd31;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("fls_err", err, 0);
        chk("fls_req2", ex_req, 0);
        tick();
        chk("fls_done", done, 0);

        // Reset mid-BUSY overrides flush and start.
        start = 1'b1; vl = 5'd16; vsew = VSEW_8;
        tick();
        start = 1'b0; ex_valid = 1'b1;
        tick();
        chk("rb_req", ex_req, 1);
        rst = 1'b1; flush = 1'b1; start = 1'b1;
        tick();
        chk_reset_vals("rb");
        rst = 1'b0; flush = 1'b0; start = 1'b0; ex_valid = 1'b0;
        tick();
        chk_reset_vals("rb_after");

        for (int i = 0; i < 40; i++) begin
            int         rv;
            logic [2:0] rs;
            rv = $urandom_range(0, 18);
            rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run_op(rv, rs, $urandom_range(0, 1), e, nw, lb);
            chk("rnd_err", e, !m_legal(rv, rs));
            chk("rnd_words", nw, m_legal(rv, rs) ? m_words(rv, rs) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
